// File: rtl/processor_pkg.sv
// Shared definitions for the processor core: opcodes, instruction field
// positions, the pipeline-register record and small decode helpers.
package processor_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 27;
    localparam int unsigned I_BIT  = 26;
    localparam int unsigned RD_HI  = 25;
    localparam int unsigned RD_LO  = 22;
    localparam int unsigned RS1_HI = 21;
    localparam int unsigned RS1_LO = 18;
    localparam int unsigned RS2_HI = 17;
    localparam int unsigned RS2_LO = 14;
    localparam int unsigned IMM_HI = 17;
    localparam int unsigned TGT_HI = 26;

    localparam logic [31:0] NOP_INSTR = {OP_NOP, 27'd0};

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  op;
        logic        imm_sel;
        logic        wr_en;
        logic [3:0]  rd;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [31:0] imm;
        logic [31:0] target;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] opd;
        logic [31:0] result;
    } pipe_t;

    function automatic pipe_t nop_pipe();
        pipe_t p;
        p    = '0;
        p.op = OP_NOP;
        return p;
    endfunction

    function automatic logic writes_reg(input logic [4:0] op);
        return (op <= OP_MOD) || (op >= OP_AND && op <= OP_ASR) ||
               (op == OP_LD) || (op == OP_CALL);
    endfunction

    function automatic logic reads_src1(input logic [4:0] op);
        return (op <= OP_OR) || (op >= OP_LSL && op <= OP_ASR) ||
               (op == OP_LD) || (op == OP_ST) || (op == OP_RET);
    endfunction

    function automatic logic reads_src2(input logic [4:0] op, input logic imm_sel);
        return !imm_sel && (op <= OP_ASR);
    endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational ALU: result for every ALU opcode plus compare flags.
module processor_alu
    import processor_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        e,
    output logic        gt
);

    always_comb begin
        result = '0;
        e      = (a == b);
        gt     = ($signed(a) > $signed(b));
        case (op)
            OP_ADD, OP_LD, OP_ST: result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_DIV:  result = (b == '0) ? '0 : a / b;
            OP_MOD:  result = (b == '0) ? '0 : a % b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~b;
            OP_MOV:  result = b;
            OP_LSL:  result = a << b[4:0];
            OP_LSR:  result = a >> b[4:0];
            OP_ASR:  result = 32'($signed(a) >>> b[4:0]);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/processor.sv
// 5-stage in-order core (IF/ID/EX/MEM/WB) with forwarding and load-use stall.
// Optional WB/branch trace compiled in with macro PROCESSOR_TRACE_EN.
module processor
    import processor_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256
) (
    input logic clk,
    input logic reset
);

    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);

    logic [31:0] Instruction_MEM [0:IMEM_DEPTH-1];
    logic [31:0] dmem [0:DMEM_DEPTH-1];
    logic [31:0] r [0:15];
    logic [31:0] pc;

    logic [31:0] if_id_instr, if_id_pc;
    pipe_t       id_ex, ex_mem, mem_wb;
    pipe_t       id_dec, ex_out, mem_out;
    logic        flag_e, flag_gt;

    logic [31:0] ex_a, ex_b, ex_d, ex_op2, alu_res, target;
    logic        alu_e, alu_gt, taken, stall;
    logic [IAW-1:0] fetch_idx;
    logic [DAW-1:0] mem_idx;

    // Write-first register read: a same-cycle WB write wins over the array.
    function automatic logic [31:0] rf_read(input logic [3:0] idx);
        return (mem_wb.wr_en && mem_wb.rd == idx) ? mem_wb.result : r[idx];
    endfunction

    function automatic logic [31:0] fwd(input logic [3:0] idx, input logic [31:0] v);
        if (ex_mem.wr_en && ex_mem.rd == idx) return ex_mem.result;
        if (mem_wb.wr_en && mem_wb.rd == idx) return mem_wb.result;
        return v;
    endfunction

    assign fetch_idx = IAW'(pc % IMEM_DEPTH);
    assign mem_idx   = DAW'(ex_mem.result % DMEM_DEPTH);

    always_comb begin
        id_dec         = nop_pipe();
        id_dec.pc      = if_id_pc;
        id_dec.op      = if_id_instr[OPC_HI:OPC_LO];
        id_dec.imm_sel = if_id_instr[I_BIT];
        id_dec.rd      = (id_dec.op == OP_CALL) ? 4'd15 : if_id_instr[RD_HI:RD_LO];
        id_dec.src1    = (id_dec.op == OP_RET) ? 4'd15 : if_id_instr[RS1_HI:RS1_LO];
        id_dec.src2    = if_id_instr[RS2_HI:RS2_LO];
        id_dec.imm     = {{14{if_id_instr[IMM_HI]}}, if_id_instr[IMM_HI:0]};
        id_dec.target  = {5'd0, if_id_instr[TGT_HI:0]};
        id_dec.wr_en   = writes_reg(id_dec.op);
        id_dec.opa     = rf_read(id_dec.src1);
        id_dec.opb     = rf_read(id_dec.src2);
        id_dec.opd     = rf_read(id_dec.rd);
        stall = (id_ex.op == OP_LD) && id_ex.wr_en &&
                ((reads_src1(id_dec.op) && id_dec.src1 == id_ex.rd) ||
                 (reads_src2(id_dec.op, id_dec.imm_sel) && id_dec.src2 == id_ex.rd) ||
                 (id_dec.op == OP_ST && id_dec.rd == id_ex.rd));
    end

    always_comb begin
        ex_a   = fwd(id_ex.src1, id_ex.opa);
        ex_b   = fwd(id_ex.src2, id_ex.opb);
        ex_d   = fwd(id_ex.rd, id_ex.opd);
        ex_op2 = id_ex.imm_sel ? id_ex.imm : ex_b;
    end

    processor_alu u_alu (
        .op     (id_ex.op),
        .a      (ex_a),
        .b      (ex_op2),
        .result (alu_res),
        .e      (alu_e),
        .gt     (alu_gt)
    );

    // Flags come from the register, which a cmp one slot ahead has just updated.
    always_comb begin
        taken  = 1'b0;
        target = id_ex.target;
        case (id_ex.op)
            OP_BEQ:        taken = flag_e;
            OP_BGT:        taken = flag_gt;
            OP_B, OP_CALL: taken = 1'b1;
            OP_RET: begin
                taken  = 1'b1;
                target = ex_a;
            end
            default: ;
        endcase
        ex_out        = id_ex;
        ex_out.opd    = ex_d;
        ex_out.result = (id_ex.op == OP_CALL) ? id_ex.pc + 32'd1 : alu_res;
    end

    always_comb begin
        mem_out = ex_mem;
        if (ex_mem.op == OP_LD) mem_out.result = dmem[mem_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            id_ex       <= nop_pipe();
            ex_mem      <= nop_pipe();
            mem_wb      <= nop_pipe();
            flag_e      <= 1'b0;
            flag_gt     <= 1'b0;
        end else begin
            if (taken)       pc <= target;
            else if (!stall) pc <= pc + 32'd1;
            if (!stall) begin
                if_id_instr <= Instruction_MEM[fetch_idx];
                if_id_pc    <= pc;
            end
            id_ex  <= stall ? nop_pipe() : id_dec;
            ex_mem <= ex_out;
            mem_wb <= mem_out;
            if (id_ex.op == OP_CMP) begin
                flag_e  <= alu_e;
                flag_gt <= alu_gt;
            end
        end
    end

    // Register file and data memory are never cleared so preloads survive reset.
    always_ff @(posedge clk) begin
        if (mem_wb.wr_en)       r[mem_wb.rd] <= mem_wb.result;
        if (ex_mem.op == OP_ST) dmem[mem_idx] <= ex_mem.opd;
    end

`ifdef PROCESSOR_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && mem_wb.wr_en)
            $display("%0t WB r%0d = %h", $time, mem_wb.rd, mem_wb.result);
        if (reset && taken)
            $display("%0t XFER pc %0d -> %0d", $time, id_ex.pc, target);
    end
`endif

endmodule

// File: tb/tb_processor.sv
// Scoreboard bench: expected register writebacks are queued per program and
// a monitor compares each WB write as the core presents it.
module tb_processor;
    import processor_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    processor #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset)
    );

    typedef struct { logic [3:0] rd; logic [31:0] val; } wb_t;
    wb_t  exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   stall_cnt = 0;
    logic mon_on    = 1'b0;

    always @(negedge clk) begin
        if (reset && dut.stall) stall_cnt++;
        if (mon_on && reset && dut.mem_wb.wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got r%0d=%h required no write",
                         dut.mem_wb.rd, dut.mem_wb.result);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if (dut.mem_wb.rd !== e.rd || dut.mem_wb.result !== e.val) begin
                    errors++;
                    $display("FAIL wb: got r%0d=%h required r%0d=%h",
                             dut.mem_wb.rd, dut.mem_wb.result, e.rd, e.val);
                end
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, 1'b0, rd, rs1, rs2, 14'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [17:0] imm);
        return {op, 1'b1, rd, rs1, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] tgt);
        return {op, tgt};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [3:0] rd, input logic [31:0] v);
        wb_t e;
        e.rd  = rd;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic begin_test();
        mon_on = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.Instruction_MEM[i] = NOP_INSTR;
        exp_q.delete();
    endtask

    task automatic go();
        stall_cnt = 0;
        mon_on    = 1'b1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d writes outstanding required 0", name, exp_q.size());
        end
        repeat (20) @(negedge clk);
    endtask

    // Prime-test program; expected write stream follows the loop's control flow.
    task automatic prime_prog(input logic [31:0] n);
        dut.Instruction_MEM[0]  = enc_i(OP_MOV, 2, 0, 18'd2);
        dut.Instruction_MEM[1]  = enc_r(OP_MOD, 3, 1, 2);
        dut.Instruction_MEM[2]  = enc_i(OP_CMP, 0, 3, 18'd0);
        dut.Instruction_MEM[3]  = enc_j(OP_BEQ, 27'd15);
        dut.Instruction_MEM[6]  = enc_i(OP_ADD, 2, 2, 18'd1);
        dut.Instruction_MEM[7]  = enc_r(OP_CMP, 0, 1, 2);
        dut.Instruction_MEM[8]  = enc_j(OP_BGT, 27'd1);
        dut.Instruction_MEM[11] = enc_i(OP_MOV, 0, 0, 18'd1);
        dut.Instruction_MEM[12] = enc_j(OP_B, 27'd16);
        dut.Instruction_MEM[15] = enc_i(OP_MOV, 0, 0, 18'd0);
        dut.Instruction_MEM[17] = enc_j(OP_B, 27'd17);
        dut.r[1] = n;
        expect_wb(2, 32'd2);
        for (int unsigned k = 2; k < 64; k++) begin
            expect_wb(3, n % k);
            if (n % k == 0) begin
                expect_wb(0, 32'd0);
                break;
            end
            expect_wb(2, k + 1);
            if (k + 1 >= n) begin
                expect_wb(0, 32'd1);
                break;
            end
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("reset_pc", dut.pc, 32'd0);
        chk("reset_ifid", dut.if_id_instr, NOP_INSTR);
        chk("reset_exmem_op", 32'(dut.ex_mem.op), 32'(OP_NOP));

        // Back-to-back RAW through forwarding, no stalls.
        begin_test();
        dut.Instruction_MEM[0] = enc_i(OP_MOV, 1, 0, 18'd5);
        dut.Instruction_MEM[1] = enc_r(OP_ADD, 2, 1, 1);
        dut.Instruction_MEM[2] = enc_i(OP_SUB, 3, 2, 18'd1);
        dut.Instruction_MEM[3] = enc_j(OP_B, 27'd3);
        expect_wb(1, 32'd5);
        expect_wb(2, 32'd10);
        expect_wb(3, 32'd9);
        go();
        drain("raw");
        chk("raw_stalls", 32'(stall_cnt), 32'd0);

        // Store, load, dependent use: one load-use bubble.
        begin_test();
        dut.r[0] = 32'd0;
        dut.r[1] = 32'd7;
        dut.Instruction_MEM[0] = enc_i(OP_ST, 1, 0, 18'd4);
        dut.Instruction_MEM[1] = enc_i(OP_LD, 4, 0, 18'd4);
        dut.Instruction_MEM[2] = enc_i(OP_ADD, 5, 4, 18'd1);
        dut.Instruction_MEM[3] = enc_j(OP_B, 27'd3);
        expect_wb(4, 32'd7);
        expect_wb(5, 32'd8);
        go();
        drain("ldst");
        chk("ldst_stalls", 32'(stall_cnt), 32'd1);
        chk("ldst_mem", dut.dmem[4], 32'd7);

        // call/ret with delay slots; the add at 4 runs once per pass.
        begin_test();
        dut.r[10] = 32'd0;
        dut.Instruction_MEM[3]  = enc_j(OP_CALL, 27'd20);
        dut.Instruction_MEM[4]  = enc_i(OP_ADD, 10, 10, 18'd1);
        dut.Instruction_MEM[6]  = enc_i(OP_MOV, 7, 0, 18'h77);
        dut.Instruction_MEM[7]  = enc_j(OP_B, 27'd7);
        dut.Instruction_MEM[20] = enc_j(OP_RET, 27'd0);
        dut.Instruction_MEM[21] = enc_i(OP_MOV, 8, 0, 18'd8);
        dut.Instruction_MEM[22] = enc_i(OP_MOV, 9, 0, 18'd9);
        expect_wb(15, 32'd4);
        expect_wb(10, 32'd1);
        expect_wb(8, 32'd8);
        expect_wb(9, 32'd9);
        expect_wb(10, 32'd2);
        expect_wb(7, 32'h77);
        go();
        drain("callret");
        chk("callret_r15", dut.r[15], 32'd4);

        // ALU edges: sign-extended imm, shifts, div by 0, unused opcode, shift mod 32.
        begin_test();
        dut.Instruction_MEM[0] = enc_i(OP_MOV, 1, 0, 18'h3FFF8);
        dut.Instruction_MEM[1] = enc_i(OP_ASR, 2, 1, 18'd1);
        dut.Instruction_MEM[2] = enc_i(OP_LSR, 3, 1, 18'd28);
        dut.Instruction_MEM[3] = enc_i(OP_DIV, 4, 1, 18'd0);
        dut.Instruction_MEM[4] = enc_r(OP_NOT, 5, 0, 1);
        dut.Instruction_MEM[5] = enc_r(OP_MUL, 6, 5, 5);
        dut.Instruction_MEM[6] = enc_i(OP_LSL, 7, 5, 18'd4);
        dut.Instruction_MEM[7] = enc_i(5'd25, 8, 0, 18'd5);
        dut.Instruction_MEM[8] = enc_i(OP_LSL, 9, 5, 18'd33);
        dut.Instruction_MEM[9] = enc_j(OP_B, 27'd9);
        expect_wb(1, 32'hFFFF_FFF8);
        expect_wb(2, 32'hFFFF_FFFC);
        expect_wb(3, 32'h0000_000F);
        expect_wb(4, 32'd0);
        expect_wb(5, 32'd7);
        expect_wb(6, 32'd49);
        expect_wb(7, 32'h70);
        expect_wb(9, 32'd14);
        go();
        drain("alu");

        begin_test();
        prime_prog(32'h2F);
        go();
        drain("prime47");
        chk("prime47_r0", dut.r[0], 32'd1);
        chk("prime47_r2", dut.r[2], 32'h2F);

        begin_test();
        prime_prog(32'h0F);
        go();
        drain("prime15");
        chk("prime15_r0", dut.r[0], 32'd0);
        chk("prime15_r2", dut.r[2], 32'd3);
        chk("prime15_r3", dut.r[3], 32'd0);

        // Reset asserted mid-loop, then the full run again from pc 0.
        begin_test();
        prime_prog(32'h2F);
        exp_q.delete();
        mon_on = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_pc", dut.pc, 32'd0);
        chk("midrst_ifid", dut.if_id_instr, NOP_INSTR);
        chk("midrst_idex_op", 32'(dut.id_ex.op), 32'(OP_NOP));
        chk("midrst_memwb_wr", 32'(dut.mem_wb.wr_en), 32'd0);
        chk("midrst_r1_kept", dut.r[1], 32'h2F);
        @(negedge clk);
        prime_prog(32'h2F);
        go();
        drain("midrst_rerun");
        chk("midrst_r0", dut.r[0], 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/processor.md
Name: processor

Overview:
- 32-bit, 5-stage in-order pipelined RISC core: IF, ID, EX, MEM, WB.
- Contains its own instruction memory, data memory, 16-entry register file and flag register.
- Programs are preloaded by hierarchical writes.
- Top-level compute block; no bus interface. Results are observed through the internal state arrays.

Parameters:
- IMEM_DEPTH, 256, instruction memory words (word-addressed).
- DMEM_DEPTH, 256, data memory words (word-addressed).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.

Behaviour:
- Required internal hierarchical names:
  - Instruction_MEM[0:IMEM_DEPTH-1] (32b).
  - r[0:15] (32b). r15 is the return-address register.
  - pc (32b word index).
  - Benches read and write these directly.
- Reset:
  - pc=0, all pipeline registers hold nop, flags E=GT=0.
  - Register file, Instruction_MEM and data memory are NOT cleared, so preloads survive.
- Instruction format:
  - [31:27] opcode; [26] I (immediate select); [25:22] rd; [21:18] rs1; [17:14] rs2.
  - [17:0] imm18, sign-extended. Operand2 = I ? imm : r[rs2].
  - Branch/call target: [26:0], an absolute word address, zero-extended.
- Opcodes:
  - add 0, sub 1, mul 2 (low 32b), div 3, mod 4 (unsigned; divisor 0 gives result 0).
  - cmp 5: E=(rs1==op2), GT=(signed rs1>op2). No register write.
  - and 6, or 7, not 8 (rd=~op2), mov 9 (rd=op2).
  - lsl 10, lsr 11, asr 12: shift amount is op2[4:0].
  - nop 13.
  - ld 14: rd=M[rs1+imm]. st 15: M[rs1+imm]=r[rd].
  - beq 16, bgt 17, b 18.
  - call 19: r15=pc_of_call+1, jump to target. ret 20: pc=r15.
  - Opcodes 21-31 execute as nop.
- Fetch: Instruction_MEM[pc]; pc increments by 1 each non-stalled cycle.
- Control transfer:
  - Resolved in EX, using the flags as of that cycle. A cmp immediately preceding a beq/bgt must be visible to it.
  - The next fetch comes from the target.
  - No flush: the two instructions already fetched (delay slots) always execute. The software inserts nops.
- Forwarding:
  - Full EX/MEM to EX and MEM/WB to EX forwarding for rs1, rs2, the st data and the ret source.
  - The register file is write-first: WB writes are visible to the same-cycle ID read.
- Load-use hazard: if the ID instruction reads the rd of an ld currently in EX, stall IF/ID for 1 cycle and insert a bubble.
- Writeback:
  - Occurs at the WB rising edge.
  - Only ALU ops except cmp/nop, plus ld and call, write a register.
  - Writes to any of r0-r15 are allowed; r0 is not hardwired.
- Address arithmetic is 32-bit; indices wrap modulo the memory depth.
- Reset asserted mid-run: the pipeline empties immediately and restarts at pc=0 after release.

Optional Feature:
- Macro PROCESSOR_TRACE_EN.
- When defined: on every WB register write, $display the time, rd and value. On every taken control transfer, $display the time, source pc and target.
- When undefined: no trace code is compiled. Functional behaviour is identical.

Decomposition:
- Package processor_pkg holds:
  - Opcode localparams (add..ret).
  - Field bit positions.
  - A pipeline-register struct typedef (pc, decoded ctrl, operands, rd, result).
- One sub-module is natural: processor_alu (combinational; op, a, b -> result, E, GT).

Test Plan:
- Prime test, r1=0x2F: program mov r2,2 / loop mod r3,r1,r2; cmp r3,0; beq 15; nop; nop; add r2,r2,1; cmp r1,r2; bgt 1; nop; nop; mov r0,1; b 16; nop; nop; [15] mov r0,0; [16] nop. Required: r0=1, r2=0x2F.
- Same program with r1=0x0F: r0=0, r2=3, r3=0.
- Back-to-back RAW (mov r1,5; add r2,r1,r1; sub r3,r2,1): r2=10, r3=9 with no stalls (forwarding).
- st r1,[r0+4] then ld r4,[r0+4]; add r5,r4,1 with r1=7: r4=7, r5=8, and exactly one stall cycle.
- call 20 from pc 3: r15=4; at [20] ret executes and execution resumes at 4 after the delay slots.
- Assert reset mid-loop: pc=0 and pipeline holds nops immediately; r-file contents retained.
